// File: rtl/xm_mem_interface.sv
// Memory-side bridge for the XMakina controller: turns a one-cycle memory request
// into a req/ack bus transaction with byte-lane steering, misalignment check and timeout.
module xm_mem_interface #(
   parameter int WORD    = 16,
   parameter int TIMEOUT = 15
) (
   input  logic            clk_i,
   input  logic            arst_ni,
   input  logic            memEn_i,
   input  logic            memRW_i,
   input  logic            byteOp_i,
   input  logic [WORD-1:0] adr_i,
   input  logic [WORD-1:0] wrData_i,
   input  logic            errClr_i,
   output logic            memBusy_o,
   output logic            memWr_o,
   output logic [WORD-1:0] rdData_o,
   output logic            busErr_o,
   output logic            busReq_o,
   output logic            busWe_o,
   output logic [WORD-1:0] busAdr_o,
   output logic [1:0]      busBe_o,
   output logic [WORD-1:0] busWdata_o,
   input  logic [WORD-1:0] busRdata_i,
   input  logic            busAck_i,
   output logic [1:0]      dbg_state_o
);

   // Bus handshake: busReq_o rises on the edge that accepts a request and stays high
   // until the edge at which busAck_i is seen high (transfer done) or the watchdog expires.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q;
   logic       misaligned, start, timeout_hit, ack_rd, to_err, set_err;
   logic [7:0] rd_lane;

   assign misaligned  = memEn_i && !byteOp_i && adr_i[0];
   assign start       = (state_q == S_IDLE) && memEn_i && !misaligned;
   assign timeout_hit = (cnt_q == TO_LAST);
   assign ack_rd      = (state_q == S_REQ) && busAck_i && !busWe_o;
   assign to_err      = (state_q == S_REQ) && !busAck_i && timeout_hit;
   assign set_err     = ((state_q == S_IDLE) && memEn_i && misaligned) || to_err;
   assign rd_lane     = (busBe_o == 2'b10) ? busRdata_i[15:8] : busRdata_i[7:0];

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (memEn_i) state_d = misaligned ? S_DONE : S_REQ;
         S_REQ:   if (busAck_i || timeout_hit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      memBusy_o   = (state_q == S_REQ);
      busReq_o    = (state_q == S_REQ);
      dbg_state_o = state_q;
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         cnt_q      <= '0;
         busWe_o    <= 1'b0;
         busAdr_o   <= '0;
         busBe_o    <= '0;
         busWdata_o <= '0;
         rdData_o   <= '0;
         memWr_o    <= 1'b0;
         busErr_o   <= 1'b0;
      end else begin
         if (start) begin
            cnt_q      <= '0;
            busWe_o    <= memRW_i;
            busAdr_o   <= {adr_i[WORD-1:1], 1'b0};
            busBe_o    <= byteOp_i ? (adr_i[0] ? 2'b10 : 2'b01) : 2'b11;
            busWdata_o <= byteOp_i ? {2{wrData_i[7:0]}} : wrData_i;
         end else if (state_q == S_REQ) begin
            cnt_q <= cnt_q + 8'd1;
         end
         // Word reads use the full bus; byte reads zero-extend the enabled lane.
         if (ack_rd)
            rdData_o <= (busBe_o == 2'b11) ? busRdata_i : {{(WORD-8){1'b0}}, rd_lane};
         memWr_o <= ack_rd;
         if (set_err)       busErr_o <= 1'b1;
         else if (errClr_i) busErr_o <= 1'b0;
      end
   end

endmodule

// File: doc/xm_mem_interface.md
# xm_mem_interface

Memory-side bridge directly downstream of the XMakina multi-cycle controller. It accepts the controller's one-cycle memory request (enable, read/write, byte/word, address, store data) and runs it as a req/ack transaction on the external memory bus. It reports completion back through the busy and data-valid signals that the controller's DECODE, MEM_CONFIRM and MEM_WRITEBACK states wait on. Byte-lane steering, misalignment detection and a bus-timeout watchdog are local to this block.

## Interface
- WORD, 16, data and address width
- TIMEOUT, 15, maximum REQ cycles before abort; must be ≥1 and fit in 8 bits

- clk_i  in  1  system clock; all state updates on the rising edge
- arst_ni  in  1  reset: one clock; reset is asynchronous and active-low
- memEn_i  in  1  request strobe from the controller, sampled only in IDLE
- memRW_i  in  1  0 = read, 1 = write
- byteOp_i  in  1  1 = byte access, 0 = word access
- adr_i  in  WORD  byte address
- wrData_i  in  WORD  store data; for byte stores only bits [7:0] are used
- errClr_i  in  1  clears busErr_o
- memBusy_o  out  1  transaction in progress
- memWr_o  out  1  one-cycle pulse: rdData_o is valid (reads only)
- rdData_o  out  WORD  load result, held until the next read completes
- busErr_o  out  1  sticky error flag (misaligned access or timeout)
- busReq_o  out  1  bus request, held until ack or abort
- busWe_o  out  1  bus write enable
- busAdr_o  out  WORD  word-aligned address, bit 0 always 0
- busBe_o  out  2  byte enables: [0] = low byte, [1] = high byte
- busWdata_o  out  WORD  bus write data
- busRdata_i  in  WORD  bus read data, valid with busAck_i
- busAck_i  in  1  bus completion

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - memEn_i=1 with byteOp_i=0 and adr_i[0]=1 is a misaligned word access. No bus cycle; set busErr_o; go to DONE with no memWr_o pulse.
  - memEn_i=1 otherwise: latch busWe_o=memRW_i, busAdr_o={adr_i[WORD-1:1],0}, busBe_o, busWdata_o and the byte/lane select; clear the timeout counter; go to REQ.
- Byte enables: a word access uses 2'b11; a byte access uses 2'b01 when adr[0]=0 and 2'b10 when adr[0]=1.
- Write data: a word access passes wrData_i through. A byte access drives {wrData_i[7:0], wrData_i[7:0]}.
- REQ:
  - busReq_o=1 and the counter increments each cycle.
  - busAck_i=1: for reads, register the read result into rdData_o. Go to DONE.
  - Counter reaches TIMEOUT with no ack: drop busReq_o, set busErr_o, leave rdData_o unchanged, go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and no error is flagged.
- Read result: a word read takes busRdata_i as is. A byte read takes the selected lane, zero-extended to WORD.
- DONE: memBusy_o=0. memWr_o=1 only if a read was acked. Unconditionally return to IDLE on the next edge, and ignore memEn_i during this cycle.
- memBusy_o is 1 exactly when the state is REQ. It is a registered-state decode, with no combinational path from memEn_i.
- memEn_i in REQ or DONE is ignored and has no queueing.
- errClr_i clears busErr_o. If errClr_i and a new error occur in the same cycle, the set wins.

## Timing
- Reset values: state IDLE; memBusy_o, memWr_o, busErr_o, busReq_o and busWe_o are 0; busAdr_o, busBe_o, busWdata_o and rdData_o are 0; counter is 0.
- Reset asserted mid-REQ drops busReq_o immediately (asynchronously). No completion is reported.
- Request is sampled at edge n; busReq_o is high from n+ onward.
- If busAck_i is high before edge n+k (k ≥ 1), DONE runs from n+k to n+k+1 and IDLE resumes at n+k+1.
- Zero-wait-state bus: memBusy_o is high for 1 cycle, memWr_o pulses in the following cycle, and the total occupancy is 2 cycles.
- The controller changes state on the falling edge. It samples memBusy_o and memWr_o half a cycle after this block updates them, so both outputs must be glitch-free registered or state decodes.
- Timeout: busReq_o is high for exactly TIMEOUT cycles, then DONE, with busErr_o high from the same edge.
- Misaligned access: DONE is entered at edge n and memBusy_o is never asserted.

## Test plan
- Word read, ack on the first REQ cycle: adr_i=0x0100, busRdata_i=0xBEEF -> busAdr_o=0x0100, busBe_o=11, memBusy_o high 1 cycle, memWr_o 1-cycle pulse, rdData_o=0xBEEF, busErr_o=0.
- Byte read, odd address, 3 wait cycles: adr_i=0x0201, busRdata_i=0x5A3C -> busAdr_o=0x0200, busBe_o=10, memBusy_o high 4 cycles, rdData_o=0x005A.
- Byte write: adr_i=0x0300, wrData_i=0x12C7, memRW_i=1 -> busWe_o=1, busBe_o=01, busWdata_o=0xC7C7, and no memWr_o pulse.
- Misaligned word write at 0x0401 -> busReq_o never rises, busErr_o=1 from the next edge; errClr_i pulse -> busErr_o=0.
- Timeout with TIMEOUT=15 and busAck_i tied low -> busReq_o high exactly 15 cycles, busErr_o=1, rdData_o keeps its prior value, no memWr_o. A second run with ack in cycle 15 -> ack wins, busErr_o=0.
- arst_ni pulsed low mid-REQ -> busReq_o=0 asynchronously, all outputs at reset values; the next memEn_i starts a clean transaction.
